// File: rtl/bist_pattern_gen.sv
`default_nettype none
// ============================================================================
// bist_pattern_gen : LFSR stimulus generator and run sequencer for logic BIST
// Revision 1.0
// ============================================================================
module bist_pattern_gen #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = 8'h01,
    parameter int               NUM_PATTERNS = 255,
    parameter int               DUT_LAT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] misr_sig,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             misr_rst,
    output logic             misr_enable,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int                  c_PCNT_W      = $clog2(NUM_PATTERNS + 1);
    localparam logic [4:0]          c_WARMUP_LAST = 5'd16;
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST   = c_PCNT_W'(NUM_PATTERNS - 1);
    localparam logic [3:0]          c_DCNT_LAST   = 4'(DUT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WARMUP  = 3'd2,
        S_RUN     = 3'd3,
        S_DRAIN   = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_seed;
    logic [4:0]          r_wcnt;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic [3:0]          r_dcnt;

    logic                w_quiet;
    logic [WIDTH-1:0]    w_seed_nxt;
    logic [WIDTH-1:0]    w_lfsr_nxt;

    assign w_quiet    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_lfsr_nxt = {pattern[WIDTH-2:0], ^(pattern & TAPS)};

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    always_comb begin
        w_seed_nxt = r_seed;
        if (w_quiet && seed_load) begin
            w_seed_nxt = (seed_in == '0) ? SEED : seed_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_seed        <= SEED;
            r_wcnt        <= '0;
            r_pcnt        <= '0;
            r_dcnt        <= '0;
            pattern       <= SEED;
            pattern_valid <= 1'b0;
            misr_rst      <= 1'b0;
            misr_enable   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            r_seed   <= w_seed_nxt;
            misr_rst <= 1'b0;
            if (abort) begin
                r_state       <= S_IDLE;
                r_wcnt        <= '0;
                r_pcnt        <= '0;
                r_dcnt        <= '0;
                pattern       <= w_seed_nxt;
                pattern_valid <= 1'b0;
                misr_enable   <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b0;
                pass          <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state  <= S_CLEAR;
                            misr_rst <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            pattern  <= w_seed_nxt;
                        end else if (r_state == S_IDLE) begin
                            pattern <= w_seed_nxt;
                        end
                    end
                    S_CLEAR: begin
                        r_state     <= S_WARMUP;
                        misr_enable <= 1'b1;
                        r_wcnt      <= '0;
                    end
                    S_WARMUP: begin
                        if (r_wcnt == c_WARMUP_LAST) begin
                            r_state       <= S_RUN;
                            pattern_valid <= 1'b1;
                            r_wcnt        <= '0;
                            r_pcnt        <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 5'd1;
                        end
                    end
                    S_RUN: begin
                        // The last pattern is held rather than stepped so DRAIN repeats it.
                        if (r_pcnt == c_PCNT_LAST) begin
                            pattern_valid <= 1'b0;
                            r_pcnt        <= '0;
                            if (DUT_LAT == 0) begin
                                r_state     <= S_COMPARE;
                                misr_enable <= 1'b0;
                            end else begin
                                r_state <= S_DRAIN;
                                r_dcnt  <= '0;
                            end
                        end else begin
                            r_pcnt  <= r_pcnt + c_PCNT_W'(1);
                            pattern <= w_lfsr_nxt;
                        end
                    end
                    S_DRAIN: begin
                        if (r_dcnt == c_DCNT_LAST) begin
                            r_state     <= S_COMPARE;
                            misr_enable <= 1'b0;
                            r_dcnt      <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 4'd1;
                        end
                    end
                    S_COMPARE: begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (misr_sig == golden_sig);
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bist_pattern_gen.sv
`default_nettype none
// tb_bist_pattern_gen : two configurations of bist_pattern_gen, each with an attached MISR,
// checked every cycle against a run-timeline model plus directed literal expectations.
module tb_bist_pattern_gen;

    localparam logic [7:0] c_TAPS = 8'hB8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in   = 8'h00;
    logic       flip      = 1'b0;
    bit         chk_en    = 1'b0;

    logic [7:0] pat_a  [2];
    logic       val_a  [2];
    logic       mrst_a [2];
    logic       men_a  [2];
    logic       busy_a [2];
    logic       done_a [2];
    logic       pass_a [2];

    int checks = 0;
    int errors = 0;

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], ^(v & c_TAPS)};
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, inst, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int NP    = (gi == 0) ? 255 : 4;
        localparam int LT    = (gi == 0) ? 0 : 3;
        localparam int T_CMP = 19 + NP + LT;

        logic [7:0] misr_q = 8'h00;
        logic [7:0] golden;

        bit         m_active   = 1'b0;
        bit         m_done     = 1'b0;
        bit         m_pass     = 1'b0;
        int         m_t        = 0;
        logic [7:0] m_seed     = 8'h01;
        logic [7:0] m_run_seed = 8'h01;
        logic [7:0] m_sig      = 8'h00;
        logic [7:0] m_pat [256];

        assign golden = m_sig ^ {7'b0, flip};

        bist_pattern_gen #(
            .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_PATTERNS(NP), .DUT_LAT(LT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .seed_load(seed_load), .seed_in(seed_in), .golden_sig(golden), .misr_sig(misr_q),
            .pattern(pat_a[gi]), .pattern_valid(val_a[gi]), .misr_rst(mrst_a[gi]),
            .misr_enable(men_a[gi]), .busy(busy_a[gi]), .done(done_a[gi]), .pass(pass_a[gi])
        );

        // Signature compactor fed directly by the pattern (datapath modelled as a wire).
        initial forever begin
            @(posedge clk);
            if (mrst_a[gi]) misr_q <= 8'h00;
            else if (men_a[gi]) misr_q <= step(misr_q) ^ pat_a[gi];
        end

        // Run timeline model: m_t counts cycles since the accepted start.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_t = 0; m_seed = 8'h01;
            end else begin
                if (!m_active && seed_load) m_seed = (seed_in == 8'h00) ? 8'h01 : seed_in;
                if (m_active) begin
                    if (abort) begin
                        m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0;
                    end else if (m_t == T_CMP) begin
                        m_active = 1'b0; m_done = 1'b1; m_pass = (flip == 1'b0);
                    end else begin
                        m_t = m_t + 1;
                    end
                end else if (abort) begin
                    m_done = 1'b0; m_pass = 1'b0;
                end else if (start) begin
                    logic [7:0] p;
                    logic [7:0] s;
                    m_active = 1'b1; m_t = 1; m_done = 1'b0; m_pass = 1'b0;
                    m_run_seed = m_seed;
                    p = m_seed;
                    for (int k = 0; k < NP; k++) begin m_pat[k] = p; p = step(p); end
                    s = 8'h00;
                    for (int k = 0; k < 17; k++) s = step(s) ^ m_run_seed;
                    for (int k = 0; k < NP; k++) s = step(s) ^ m_pat[k];
                    for (int k = 0; k < LT; k++) s = step(s) ^ m_pat[NP-1];
                    m_sig = s;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", gi, busy_a[gi], m_active);
                check("done", gi, done_a[gi], m_done);
                check("pass", gi, pass_a[gi], m_pass);
                check("misr_rst", gi, mrst_a[gi], m_active && m_t == 1);
                check("misr_enable", gi, men_a[gi], m_active && m_t >= 2 && m_t <= T_CMP - 1);
                check("pattern_valid", gi, val_a[gi], m_active && m_t >= 19 && m_t <= 18 + NP);
                if (!m_active && !m_done)
                    check("pattern_idle", gi, pat_a[gi], m_seed);
                else if (m_active && m_t <= 18)
                    check("pattern_warm", gi, pat_a[gi], m_run_seed);
                else if (m_active && m_t <= 18 + NP)
                    check("pattern_run", gi, pat_a[gi], m_pat[m_t-19]);
                else if (m_active && m_t < T_CMP)
                    check("pattern_drain", gi, pat_a[gi], m_pat[NP-1]);
            end
        end
    end

    task automatic wait_done();
        int k = 0;
        while (!(done_a[0] && done_a[1]) && k < 600) begin @(negedge clk); k++; end
        check("run_finished", 0, done_a[0] && done_a[1], 1);
    endtask

    task automatic run_first(input logic [7:0] exp);
        int k = 0;
        start = 1'b1; @(negedge clk); start = 1'b0; seed_load = 1'b0;
        while (!val_a[0] && k < 60) begin @(negedge clk); k++; end
        check("first_run_cycle", 0, k, 18);
        check("first_run_pattern", 0, pat_a[0], exp);
        check("first_run_pattern", 1, pat_a[1], exp);
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 2; i++) begin
            check("rst_pattern", i, pat_a[i], 8'h01);
            check("rst_flags", i, {val_a[i], mrst_a[i], men_a[i], busy_a[i], done_a[i], pass_a[i]}, 6'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rst0, en0, en1, val1, nv, dn0, dn1;
        logic [7:0] first7 [7];
        logic [7:0] exp7 [7];
        exp7 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
        first7 = '{default: 8'h00};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Default-seed run on both configurations, framing counted per cycle.
        flip = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        rst0 = 0; en0 = 0; en1 = 0; val1 = 0; nv = 0; dn0 = 0; dn1 = 0;
        for (int c = 1; c <= 400; c++) begin
            if (mrst_a[0]) rst0++;
            if (men_a[0]) en0++;
            if (men_a[1]) en1++;
            if (val_a[1]) val1++;
            if (val_a[0]) begin
                if (nv < 7) first7[nv] = pat_a[0];
                nv++;
            end
            if (done_a[0] && dn0 == 0) dn0 = c;
            if (done_a[1] && dn1 == 0) dn1 = c;
            if (dn0 != 0 && dn1 != 0) break;
            @(negedge clk);
        end
        check("done_cycle", 0, dn0, 275);
        check("done_cycle", 1, dn1, 27);
        check("misr_rst_pulses", 0, rst0, 1);
        check("misr_enable_cycles", 0, en0, 272);
        check("misr_enable_cycles", 1, en1, 24);
        check("valid_cycles", 0, nv, 255);
        check("valid_cycles", 1, val1, 4);
        for (int i = 0; i < 7; i++) check("seq_pattern", i, first7[i], exp7[i]);
        check("pass_good_golden", 0, pass_a[0], 1);
        check("pass_good_golden", 1, pass_a[1], 1);

        // Wrong golden; start and seed_load while busy must be ignored.
        flip = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        seed_load = 1'b1; seed_in = 8'hC3; start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        wait_done();
        check("pass_bad_golden", 0, pass_a[0], 0);
        check("pass_bad_golden", 1, pass_a[1], 0);
        flip = 1'b0;
        run_first(8'h01);
        wait_done();

        // Zero seed falls back to the default; seed loaded with start is used at once.
        seed_load = 1'b1; seed_in = 8'h33; @(negedge clk);
        seed_in = 8'h00; @(negedge clk);
        seed_load = 1'b0;
        run_first(8'h01);
        wait_done();
        seed_load = 1'b1; seed_in = 8'h5A;
        run_first(8'h5A);
        wait_done();
        check("pass_seed_5a", 0, pass_a[0], 1);

        // Abort in the 10th RUN cycle, then abort together with start.
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (27) @(negedge clk);
        check("abort_in_run", 0, val_a[0], 1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("abort_busy", 0, busy_a[0], 0);
        check("abort_enable", 0, men_a[0], 0);
        check("abort_done", 0, done_a[0], 0);
        check("abort_done", 1, done_a[1], 0);
        abort = 1'b1; start = 1'b1; @(negedge clk); abort = 1'b0; start = 1'b0;
        check("abort_start_busy", 0, busy_a[0], 0);
        check("abort_start_busy", 1, busy_a[1], 0);

        // Asynchronous reset in WARMUP, seed register included.
        seed_load = 1'b1; seed_in = 8'h77; @(negedge clk); seed_load = 1'b0;
        check("idle_seed", 0, pat_a[0], 8'h77);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        check("warmup_enable", 0, men_a[0], 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_first(8'h01);
        wait_done();
        check("pass_after_reset", 0, pass_a[0], 1);
        check("pass_after_reset", 1, pass_a[1], 1);

        // Randomized runs with sporadic abort, busy-time start and seed_load.
        for (int r = 0; r < 12; r++) begin
            int k;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            flip = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                seed_load = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            start = 1'b1; @(negedge clk);
            start = 1'b0; seed_load = 1'b0;
            k = 0;
            while ((busy_a[0] || busy_a[1]) && k < 600) begin
                abort     = ($urandom_range(0, 299) == 0);
                start     = (k < 150) && ($urandom_range(0, 19) == 0);
                seed_load = ($urandom_range(0, 19) == 0);
                seed_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                @(negedge clk);
                k++;
            end
            abort = 1'b0; start = 1'b0; seed_load = 1'b0;
            check("random_run_quiet", r, busy_a[0] || busy_a[1], 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
